// File: rtl/anc_tx_sync_ctrl.sv
// Anchor-side transmit sequencer: sync pattern on the front-panel GPIO,
// idle gap, then NSYMB tone symbols of NSIG samples as phase words for the DDS.
// Optional feature macro: ANC_TX_REPEAT_EN adds the repeat_frame input, which
// chains the next frame straight into SYNC without an IDLE cycle.
//
// state  | meaning
// IDLE   | waiting for start, outputs at idle values
// SYNC   | driving SYNC_PATTERN on fp_gpio_out for SYNC_SIG_N cycles
// GAP    | GPIO low for GAP_N cycles
// TX     | streaming ph/ph_inc, NSIG samples per symbol, NSYMB symbols
module anc_tx_sync_ctrl #(
  parameter int unsigned PHASE_WIDTH = 24,
  parameter int unsigned NSYMB_WIDTH = 16,
  parameter int unsigned REG_WIDTH   = 12,
  parameter int unsigned NSIG        = 1024,
  parameter int unsigned NSYMB       = 16,
  parameter int unsigned SYNC_SIG_N  = 32678,
  parameter int unsigned GAP_N       = 256,
  parameter logic [REG_WIDTH-1:0]   SYNC_PATTERN = 12'h044,
  parameter logic [PHASE_WIDTH-1:0] PH_INC_BASE  = 24'h001000,
  parameter logic [PHASE_WIDTH-1:0] PH_INC_STEP  = 24'h000400
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
`ifdef ANC_TX_REPEAT_EN
  input  logic                   repeat_frame,
`endif
  output logic [REG_WIDTH-1:0]   fp_gpio_out,
  output logic [REG_WIDTH-1:0]   fp_gpio_ddr,
  output logic [1:0]             tx_state,
  output logic                   tx_valid,
  output logic [PHASE_WIDTH-1:0] ph,
  output logic [PHASE_WIDTH-1:0] ph_inc,
  output logic [NSYMB_WIDTH-1:0] symbN,
  output logic                   done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_GAP  = 2'd2,
    S_TX   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [REG_WIDTH-1:0]   gout_q, gout_d;
  logic                   valid_q, valid_d;
  logic [PHASE_WIDTH-1:0] ph_q, ph_d;
  logic [PHASE_WIDTH-1:0] inc_q, inc_d;
  logic [NSYMB_WIDTH-1:0] symb_q, symb_d;
  logic                   done_q, done_d;
  logic                   rep_req;

`ifdef ANC_TX_REPEAT_EN
  assign rep_req = repeat_frame;
`else
  assign rep_req = 1'b0;
`endif

  // Register every output; the direction word latches the pattern on the first clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      gout_q      <= '0;
      valid_q     <= 1'b0;
      ph_q        <= '0;
      inc_q       <= '0;
      symb_q      <= '0;
      done_q      <= 1'b0;
      fp_gpio_ddr <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gout_q      <= gout_d;
      valid_q     <= valid_d;
      ph_q        <= ph_d;
      inc_q       <= inc_d;
      symb_q      <= symb_d;
      done_q      <= done_d;
      fp_gpio_ddr <= SYNC_PATTERN;
    end
  end

  // Next-state and next-output logic; cnt is a down-counter reloaded on each phase/symbol.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gout_d  = gout_q;
    valid_d = valid_q;
    ph_d    = ph_q;
    inc_d   = inc_q;
    symb_d  = symb_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      gout_d  = '0;
      valid_d = 1'b0;
      ph_d    = '0;
      inc_d   = '0;
      symb_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_SYNC;
            cnt_d   = SYNC_SIG_N - 1;
            gout_d  = SYNC_PATTERN;
          end
        end
        S_SYNC: begin
          if (cnt_q == '0) begin
            state_d = S_GAP;
            cnt_d   = GAP_N - 1;
            gout_d  = '0;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            state_d = S_TX;
            cnt_d   = NSIG - 1;
            valid_d = 1'b1;
            ph_d    = '0;
            inc_d   = PH_INC_BASE;
            symb_d  = '0;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        S_TX: begin
          ph_d = ph_q + inc_q;
          if (cnt_q == '0) begin
            if (symb_q == NSYMB_WIDTH'(NSYMB - 1)) begin
              done_d  = 1'b1;
              valid_d = 1'b0;
              ph_d    = '0;
              inc_d   = '0;
              symb_d  = '0;
              if (rep_req) begin
                state_d = S_SYNC;
                cnt_d   = SYNC_SIG_N - 1;
                gout_d  = SYNC_PATTERN;
              end else begin
                state_d = S_IDLE;
                cnt_d   = '0;
              end
            end else begin
              symb_d = symb_q + NSYMB_WIDTH'(1);
              ph_d   = '0;
              inc_d  = inc_q + PH_INC_STEP;
              cnt_d  = NSIG - 1;
            end
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign tx_state    = state_q;
  assign fp_gpio_out = gout_q;
  assign tx_valid    = valid_q;
  assign ph          = ph_q;
  assign ph_inc      = inc_q;
  assign symbN       = symb_q;
  assign done        = done_q;

endmodule

// File: tb/tb_anc_tx_sync_ctrl.sv
// Directed bench for anc_tx_sync_ctrl with a per-cycle expected-output scoreboard.
// Define ANC_TX_REPEAT_EN to also exercise frame chaining.
module tb_anc_tx_sync_ctrl;

  localparam int unsigned SYNC_N = 8;
  localparam int unsigned GAP    = 4;
  localparam int unsigned NS     = 4;
  localparam int unsigned NSY    = 3;
  localparam logic [11:0] PAT    = 12'h044;
  localparam logic [23:0] BASE   = 24'h000100;
  localparam logic [23:0] STEP   = 24'h000040;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
`ifdef ANC_TX_REPEAT_EN
  logic repeat_frame = 1'b0;
`endif
  logic [11:0] fp_gpio_out, fp_gpio_ddr;
  logic [1:0]  tx_state;
  logic        tx_valid, done;
  logic [23:0] ph, ph_inc;
  logic [15:0] symbN;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  st;
    logic [11:0] gout;
    logic        valid;
    logic [23:0] ph;
    logic [23:0] inc;
    logic [15:0] sym;
    logic        done;
  } exp_t;

  exp_t sb[$];

  anc_tx_sync_ctrl #(
    .PHASE_WIDTH(24), .NSYMB_WIDTH(16), .REG_WIDTH(12),
    .NSIG(NS), .NSYMB(NSY), .SYNC_SIG_N(SYNC_N), .GAP_N(GAP),
    .SYNC_PATTERN(PAT), .PH_INC_BASE(BASE), .PH_INC_STEP(STEP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
`ifdef ANC_TX_REPEAT_EN
    .repeat_frame(repeat_frame),
`endif
    .fp_gpio_out(fp_gpio_out), .fp_gpio_ddr(fp_gpio_ddr), .tx_state(tx_state),
    .tx_valid(tx_valid), .ph(ph), .ph_inc(ph_inc), .symbN(symbN), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] st, input logic [11:0] g, input logic v,
                              input logic [23:0] p, input logic [23:0] inc,
                              input logic [15:0] s, input logic d);
    exp_t e;
    e.st = st; e.gout = g; e.valid = v; e.ph = p; e.inc = inc; e.sym = s; e.done = d;
    return e;
  endfunction

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) sb.push_back(mk(2'd0, 12'h0, 1'b0, 24'h0, 24'h0, 16'h0, 1'b0));
  endtask

  task automatic push_frame(input int nsync, input bit rep_end);
    logic [23:0] inc;
    for (int i = 0; i < nsync; i++) sb.push_back(mk(2'd1, PAT, 1'b0, 24'h0, 24'h0, 16'h0, 1'b0));
    for (int i = 0; i < int'(GAP); i++) sb.push_back(mk(2'd2, 12'h0, 1'b0, 24'h0, 24'h0, 16'h0, 1'b0));
    for (int s = 0; s < int'(NSY); s++) begin
      inc = BASE + 24'(s) * STEP;
      for (int n = 0; n < int'(NS); n++)
        sb.push_back(mk(2'd3, 12'h0, 1'b1, 24'(n) * inc, inc, 16'(s), 1'b0));
    end
    if (rep_end) sb.push_back(mk(2'd1, PAT, 1'b0, 24'h0, 24'h0, 16'h0, 1'b1));
    else         sb.push_back(mk(2'd0, 12'h0, 1'b0, 24'h0, 24'h0, 16'h0, 1'b1));
  endtask

  // Wait one cycle, then compare the DUT outputs against the oldest expectation.
  task automatic step(input string tag);
    exp_t e;
    @(negedge clk);
    chk({tag, "_sb_empty"}, 32'(sb.size() == 0), 32'd0);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_state"}, 32'(tx_state), 32'(e.st));
      chk({tag, "_gpio_out"}, 32'(fp_gpio_out), 32'(e.gout));
      chk({tag, "_gpio_ddr"}, 32'(fp_gpio_ddr), 32'(PAT));
      chk({tag, "_valid"}, 32'(tx_valid), 32'(e.valid));
      chk({tag, "_ph"}, 32'(ph), 32'(e.ph));
      chk({tag, "_ph_inc"}, 32'(ph_inc), 32'(e.inc));
      chk({tag, "_symbN"}, 32'(symbN), 32'(e.sym));
      chk({tag, "_done"}, 32'(done), 32'(e.done));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 32'(tx_state), 32'd0);
    chk({tag, "_gpio_out"}, 32'(fp_gpio_out), 32'd0);
    chk({tag, "_gpio_ddr"}, 32'(fp_gpio_ddr), 32'd0);
    chk({tag, "_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_ph"}, 32'(ph), 32'd0);
    chk({tag, "_ph_inc"}, 32'(ph_inc), 32'd0);
    chk({tag, "_symbN"}, 32'(symbN), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    // reset held for five cycles, then idle with the direction word set
    repeat (5) begin
      @(negedge clk);
      chk_zero("t1_rst");
    end
    reset = 1'b0;
    push_idle(3);
    repeat (3) step("t1_idle");

    // full frame: sync, gap, three symbols, done, then quiet idle
    start = 1'b1;
    push_frame(SYNC_N, 1'b0);
    push_idle(3);
    step("t2");
    start = 1'b0;
    repeat (27) step("t2");

    // abort on the third gap cycle, with extra starts during sync and at the abort
    for (int i = 0; i < int'(SYNC_N); i++) sb.push_back(mk(2'd1, PAT, 1'b0, 24'h0, 24'h0, 16'h0, 1'b0));
    for (int i = 0; i < 3; i++) sb.push_back(mk(2'd2, 12'h0, 1'b0, 24'h0, 24'h0, 16'h0, 1'b0));
    push_idle(5);
    start = 1'b1;
    step("t4");
    start = 1'b0;
    step("t4");
    step("t4");
    start = 1'b1;
    step("t4");
    start = 1'b0;
    repeat (7) step("t4");
    abort = 1'b1;
    start = 1'b1;
    step("t4_abort");
    abort = 1'b0;
    start = 1'b0;
    repeat (4) step("t4_idle");

`ifdef ANC_TX_REPEAT_EN
    // chained frames: done coincides with the first SYNC cycle of the next frame
    repeat_frame = 1'b1;
    start = 1'b1;
    push_frame(SYNC_N, 1'b1);
    push_frame(SYNC_N - 1, 1'b0);
    push_idle(2);
    step("t5");
    start = 1'b0;
    repeat (24) step("t5");
    repeat_frame = 1'b0;
    repeat (26) step("t5b");
`endif

    // asynchronous reset in the middle of symbol 1, then a clean frame
    start = 1'b1;
    push_frame(SYNC_N, 1'b0);
    step("t6");
    start = 1'b0;
    repeat (17) step("t6");
    chk("t6_mid_symbN", 32'(symbN), 32'd1);
    sb.delete();
    #2 reset = 1'b1;
    #1 chk_zero("t6_async");
    @(negedge clk);
    chk_zero("t6_hold");
    reset = 1'b0;
    push_idle(2);
    step("t6_idle");
    step("t6_idle");
    start = 1'b1;
    push_frame(SYNC_N, 1'b0);
    push_idle(2);
    step("t6_frame");
    start = 1'b0;
    repeat (26) step("t6_frame");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
